corelet_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the corelet and drives its 12-bit control word. For each of `len_kij` kernel positions it moves weights and activations from activation/weight SRAM (xmem) into L0, runs kernel load and execution on the MAC array, and drains the output FIFO into partial-sum SRAM (pmem). It is started by a one-cycle `start` pulse and signals completion with a one-cycle `done` pulse.

---
 rtl/corelet_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl.sv
// Sequencing controller for the corelet: per kernel position it loads weights and
// activations from xmem into L0, runs the MAC array and drains the output FIFO into pmem.
module corelet_ctrl #(
  parameter int unsigned bw       = 4,
  parameter int unsigned psum_bw  = 16,
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned len_kij  = 9,
  parameter int unsigned len_nij  = 36,
  parameter logic [10:0] w_base   = 11'd1024,
  parameter logic [10:0] a_base   = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [11:0] in_ctrl,
  output logic        xmem_cen,
  output logic        xmem_wen,
  output logic [10:0] xmem_addr,
  output logic        pmem_cen,
  output logic        pmem_wen,
  output logic [10:0] pmem_addr,
  output logic        busy,
  output logic        done
);

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int unsigned MaxCnt = max3(col, row + col, len_nij);
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned KijW   = (len_kij > 1) ? $clog2(len_kij) : 1;

  if (bw == 0 || psum_bw < bw || row == 0 || col == 0 || len_kij == 0 || len_nij == 0)
  begin : g_bad_cfg
    $error("corelet_ctrl: invalid parameter set");
  end

  typedef enum logic [2:0] {
    StIdle, StWload, StWprop, StWflush, StAload, StExec, StDrain, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [KijW-1:0]   kij_q, kij_d;
  // wr marks a cycle in which a pmem write (and ofifo_rd) is presented.
  logic              wr_q, wr_d;

  logic [11:0] in_ctrl_d;
  logic        xmem_cen_d, pmem_cen_d, pmem_wen_d, busy_d, done_d;
  logic [10:0] xmem_addr_d, pmem_addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    wr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWload;
          cnt_d   = '0;
          kij_d   = '0;
        end
      end
      StWload: begin
        if (cnt_q == CntW'(col)) begin
          state_d = StWprop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWprop: begin
        if (cnt_q == CntW'(col - 1)) begin
          state_d = StWflush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWflush: begin
        if (cnt_q == CntW'(row + col - 1)) begin
          state_d = StAload;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAload: begin
        if (cnt_q == CntW'(len_nij)) begin
          state_d = StExec;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StExec: begin
        if (cnt_q == CntW'(len_nij - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
          wr_d    = ofifo_valid;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        // Outputs are registered, so the valid seen this cycle schedules next cycle's write.
        if (wr_q && cnt_q == CntW'(len_nij - 1)) begin
          cnt_d = '0;
          if (kij_q == KijW'(len_kij - 1)) begin
            state_d = StFin;
          end else begin
            kij_d   = kij_q + KijW'(1);
            state_d = StWload;
          end
        end else begin
          cnt_d = cnt_q + CntW'(wr_q);
          wr_d  = ofifo_valid;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded from the next-state values so they line up with the state.
  always_comb begin
    in_ctrl_d   = '0;
    xmem_cen_d  = 1'b1;
    xmem_addr_d = '0;
    pmem_cen_d  = 1'b1;
    pmem_wen_d  = 1'b1;
    pmem_addr_d = pmem_addr;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFin);
    unique case (state_d)
      StWload: begin
        if (cnt_d < CntW'(col)) begin
          xmem_cen_d  = 1'b0;
          xmem_addr_d = w_base + 11'(32'(kij_d) * col) + 11'(cnt_d);
        end
        in_ctrl_d[2] = (cnt_d != '0);
      end
      StAload: begin
        if (cnt_d < CntW'(len_nij)) begin
          xmem_cen_d  = 1'b0;
          xmem_addr_d = a_base + 11'(cnt_d);
        end
        in_ctrl_d[2] = (cnt_d != '0);
      end
      StWprop: begin
        in_ctrl_d[3]   = 1'b1;
        in_ctrl_d[1:0] = 2'b01;
      end
      StExec: begin
        in_ctrl_d[3]   = 1'b1;
        in_ctrl_d[1:0] = 2'b10;
      end
      StDrain: begin
        if (wr_d) begin
          in_ctrl_d[6] = 1'b1;
          pmem_cen_d   = 1'b0;
          pmem_wen_d   = 1'b0;
          pmem_addr_d  = 11'(32'(kij_d) * len_nij) + 11'(cnt_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      kij_q     <= '0;
      wr_q      <= 1'b0;
      in_ctrl   <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kij_q     <= kij_d;
      wr_q      <= wr_d;
      in_ctrl   <= in_ctrl_d;
      xmem_cen  <= xmem_cen_d;
      xmem_addr <= xmem_addr_d;
      pmem_cen  <= pmem_cen_d;
      pmem_wen  <= pmem_wen_d;
      pmem_addr <= pmem_addr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign xmem_wen = 1'b1;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: a single-kij instance and a default instance share stimulus.
module tb_corelet_ctrl;

  logic clk, reset, start, ofifo_valid;

  logic [11:0] ictl1, ictlf;
  logic        xcen1, xwen1, pcen1, pwen1, busy1, done1;
  logic        xcenf, xwenf, pcenf, pwenf, busyf, donef;
  logic [10:0] xaddr1, paddr1, xaddrf, paddrf;

  corelet_ctrl #(.len_kij(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .in_ctrl(ictl1), .xmem_cen(xcen1), .xmem_wen(xwen1), .xmem_addr(xaddr1),
    .pmem_cen(pcen1), .pmem_wen(pwen1), .pmem_addr(paddr1), .busy(busy1), .done(done1)
  );

  corelet_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .in_ctrl(ictlf), .xmem_cen(xcenf), .xmem_wen(xwenf), .xmem_addr(xaddrf),
    .pmem_cen(pcenf), .pmem_wen(pwenf), .pmem_addr(paddrf), .busy(busyf), .done(donef)
  );

  localparam logic [39:0] RstVal = {12'h0, 1'b1, 1'b1, 11'h0, 1'b1, 1'b1, 11'h0, 1'b0, 1'b0};

  logic [39:0] o1, of;
  assign o1 = {ictl1, xcen1, xwen1, xaddr1, pcen1, pwen1, paddr1, busy1, done1};
  assign of = {ictlf, xcenf, xwenf, xaddrf, pcenf, pwenf, paddrf, busyf, donef};

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run A counters (single-kij instance, then default instance)
  int w1_n = 0, w1_bad = 0, a1_n = 0, a1_bad = 0, l0_n = 0, l0_bad = 0;
  int p01_n = 0, p01_bad = 0, p10_n = 0, p10_bad = 0, fl_bad = 0;
  int p1_n = 0, p1_bad = 0, d1_n = 0, d1_c = 0, busy_bad = 0;
  int pf_n = 0, pf_bad = 0, wf_n = 0, wf_bad = 0, df_n = 0, df_c = 0;
  logic prev_cen1;
  // Run B / C counters
  int pb_n = 0, pb_bad = 0, db_n = 0, dc_n = 0;
  logic vhist [0:400];
  logic [1:0] inst_at_505;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    #2;
    chk("rst_async_dut1", 64'(o1), 64'(RstVal));
    chk("rst_async_dut", 64'(of), 64'(RstVal));
    repeat (3) step();
    chk("rst_held_dut", 64'(of), 64'(RstVal));
    reset = 1'b0;
    repeat (50) step();
    chk("idle50_busy", 64'(busyf), 64'(0));
    chk("idle50_in_ctrl", 64'(ictlf), 64'(0));
    chk("idle50_all", 64'(o1), 64'(RstVal));

    // Run A: valid tied high, extra start pulses in EXEC and in the FIN cycle
    ofifo_valid = 1'b1;
    prev_cen1 = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 1300; c++) begin
      step();
      if (c == 1 || c == 81 || c == 144) start = 1'b0;
      if (c == 80 || c == 143) start = 1'b1;
      if (!xcen1) begin
        if (xaddr1 >= 11'd1024) begin
          if (c != 1 + w1_n || xaddr1 != 11'(1024 + w1_n)) w1_bad++;
          w1_n++;
        end else begin
          if (c != 34 + a1_n || xaddr1 != 11'(a1_n)) a1_bad++;
          a1_n++;
        end
      end
      if (ictl1[2]) begin
        l0_n++;
        if (prev_cen1) l0_bad++;
      end
      prev_cen1 = xcen1;
      if (ictl1[1:0] == 2'b01) begin
        p01_n++;
        if (!ictl1[3] || c < 10 || c > 17) p01_bad++;
      end
      if (ictl1[1:0] == 2'b10) begin
        p10_n++;
        if (!ictl1[3] || c < 71 || c > 106) p10_bad++;
      end
      if (c >= 18 && c <= 33 && (ictl1 != 12'h0 || !xcen1 || !pcen1)) fl_bad++;
      if (!pcen1) begin
        if (pwen1 || !ictl1[6] || paddr1 != 11'(p1_n) || c != 107 + p1_n) p1_bad++;
        p1_n++;
      end
      if (done1) begin
        d1_n++;
        d1_c = c;
      end
      if (busy1 != (c <= 143)) busy_bad++;
      if (!pcenf) begin
        if (paddrf != 11'(pf_n) || !ictlf[6]) pf_bad++;
        pf_n++;
      end
      if (!xcenf && xaddrf >= 11'd1024) begin
        if (wf_n >= 64 && xaddrf != 11'(1088 + wf_n - 64)) wf_bad++;
        wf_n++;
      end
      if (donef) begin
        df_n++;
        df_c = c;
      end
    end
    chk("k1_wread_count", 64'(w1_n), 64'(8));
    chk("k1_wread_addr_time", 64'(w1_bad), 64'(0));
    chk("k1_aread_count", 64'(a1_n), 64'(36));
    chk("k1_aread_addr_time", 64'(a1_bad), 64'(0));
    chk("k1_l0wr_count", 64'(l0_n), 64'(44));
    chk("k1_l0wr_lag", 64'(l0_bad), 64'(0));
    chk("k1_wprop_count", 64'(p01_n), 64'(8));
    chk("k1_wprop_window", 64'(p01_bad), 64'(0));
    chk("k1_flush_quiet", 64'(fl_bad), 64'(0));
    chk("k1_exec_count", 64'(p10_n), 64'(36));
    chk("k1_exec_window", 64'(p10_bad), 64'(0));
    chk("k1_pmem_count", 64'(p1_n), 64'(36));
    chk("k1_pmem_addr_time", 64'(p1_bad), 64'(0));
    chk("k1_done_count", 64'(d1_n), 64'(1));
    chk("k1_done_cycle", 64'(d1_c), 64'(143));
    chk("k1_busy_window", 64'(busy_bad), 64'(0));
    chk("full_pmem_count", 64'(pf_n), 64'(324));
    chk("full_pmem_contig", 64'(pf_bad), 64'(0));
    chk("full_wread_count", 64'(wf_n), 64'(72));
    chk("full_kij8_waddr", 64'(wf_bad), 64'(0));
    chk("full_done_count", 64'(df_n), 64'(1));
    chk("full_done_cycle", 64'(df_c), 64'(1279));

    // Run B: ofifo_valid pattern 1,0,0,1,0,0,...
    ofifo_valid = 1'b1;
    vhist[0] = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (!pcen1) begin
        if (pwen1 || !ictl1[6] || paddr1 != 11'(pb_n) || !vhist[c-1]) pb_bad++;
        pb_n++;
      end else if (ictl1[6]) begin
        pb_bad++;
      end
      if (done1) db_n++;
      ofifo_valid = (c % 3 == 0);
      vhist[c] = ofifo_valid;
    end
    chk("stall_pmem_count", 64'(pb_n), 64'(36));
    chk("stall_writes_ok", 64'(pb_bad), 64'(0));
    chk("stall_done_count", 64'(db_n), 64'(1));

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Run C: reset during kij=3 EXEC, then restart
    ofifo_valid = 1'b1;
    start = 1'b1;
    inst_at_505 = 2'b00;
    for (int c = 1; c <= 505; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (donef) dc_n++;
      if (c == 505) inst_at_505 = ictlf[1:0];
    end
    chk("kij3_in_exec", 64'(inst_at_505), 64'(2));
    #3 reset = 1'b1;
    #1;
    chk("midrun_rst_async", 64'(of), 64'(RstVal));
    chk("midrun_no_done", 64'(dc_n), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_cen", 64'(xcenf), 64'(0));
    chk("restart_addr0", 64'(xaddrf), 64'(1024));
    chk("restart_busy", 64'(busyf), 64'(1));
    step();
    chk("restart_addr1", 64'(xaddrf), 64'(1025));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
